// File: rtl/periphery_pkg.sv
// Shared widths, host opcodes, status-word layout and decoder FSM states
// used by io_cmd_decoder and its command buffer.
package periphery_pkg;

   localparam int INPUT_DATA_L  = 32;
   localparam int OUTPUT_DATA_L = 32;
   localparam int IO_OPCODE_L   = 3;
   localparam int ADDR_L        = 16;
   localparam int MEM_DATA_L    = 32;

   typedef enum logic [IO_OPCODE_L-1:0] {
      OP_NOP      = 3'd0,
      OP_SET_ADDR = 3'd1,
      OP_WRITE    = 3'd2,
      OP_READ     = 3'd3,
      OP_STATUS   = 3'd4,
      OP_CLR_ERR  = 3'd5,
      OP_RSVD6    = 3'd6,
      OP_RSVD7    = 3'd7
   } io_opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RWAIT = 2'd2
   } fsm_t;

   // Status word: flags on top, optional write count in the pad, address at the bottom.
   localparam int STAT_OVF    = 31;
   localparam int STAT_OP     = 30;
   localparam int STAT_BUSY   = 29;
   localparam int STAT_DONE   = 28;
   localparam int STAT_PAD_HI = 27;
   localparam int STAT_PAD_LO = 16;

   function automatic logic is_mem_op(input io_opcode_t op);
      return (op == OP_WRITE) || (op == OP_READ);
   endfunction

endpackage

// File: rtl/io_cmd_buf.sv
// One-entry pending slot for WRITE/READ commands that arrive while a memory
// transaction is in flight; a push into a full, non-draining slot is dropped.
module io_cmd_buf
   import periphery_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  push_we,
   input  logic [MEM_DATA_L-1:0] push_data,
   input  logic                  pop,
   input  logic                  clr_err,
   output logic                  valid,
   output logic                  we,
   output logic [MEM_DATA_L-1:0] data,
   output logic                  err_ovf
);

   logic ovf_evt;

   assign ovf_evt = push && valid && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         we    <= 1'b0;
         data  <= '0;
      end else if (push && (!valid || pop)) begin
         valid <= 1'b1;
         we    <= push_we;
         data  <= push_data;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

   // A drop in the same cycle as CLR_ERR leaves the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         err_ovf <= 1'b0;
      else if (ovf_evt) err_ovf <= 1'b1;
      else if (clr_err) err_ovf <= 1'b0;
   end

endmodule

// File: rtl/io_cmd_decoder.sv
// Host opcode/data decoder: memory write/read sequencing, status readback and
// execution control. Define IO_WR_CNT_EN to add a granted-write counter to STATUS.
module io_cmd_decoder
   import periphery_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INPUT_DATA_L-1:0]  in_core,
   input  logic [IO_OPCODE_L-1:0]   io_opcode_core,
   input  logic                     reset_execution_io_core,
   input  logic                     enable_execution_io_core,
   output logic                     done_execution_io_core,
   output logic [OUTPUT_DATA_L-1:0] out_core,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_L-1:0]        mem_addr,
   output logic [MEM_DATA_L-1:0]    mem_wdata,
   input  logic                     mem_gnt,
   input  logic                     mem_rvalid,
   input  logic [MEM_DATA_L-1:0]    mem_rdata,
   output logic                     exec_start,
   output logic                     exec_reset,
   input  logic                     exec_done,
   output fsm_t                     fsm_state
);

   io_opcode_t               op_q;
   logic [INPUT_DATA_L-1:0]  in_q;
   logic                     rst_exec_q, en_q, en_prev;
   fsm_t                     state, state_n;
   logic                     take_buf, take_in, gnt_fire, rd_fire;
   logic                     buf_valid, buf_we, err_ovf, err_op, done_q;
   logic [MEM_DATA_L-1:0]    buf_data;
   logic [ADDR_L-1:0]        addr_q;
   logic [OUTPUT_DATA_L-1:0] out_q, status_word;
   logic                     is_set, is_status, is_clr, is_rsvd, busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= OP_NOP;
         in_q       <= '0;
         rst_exec_q <= 1'b0;
         en_q       <= 1'b0;
         en_prev    <= 1'b0;
      end else begin
         op_q       <= io_opcode_t'(io_opcode_core);
         in_q       <= in_core;
         rst_exec_q <= reset_execution_io_core;
         en_q       <= enable_execution_io_core;
         en_prev    <= en_q;
      end
   end

   assign is_set    = (op_q == OP_SET_ADDR);
   assign is_status = (op_q == OP_STATUS);
   assign is_clr    = (op_q == OP_CLR_ERR);
   assign is_rsvd   = (op_q == OP_RSVD6) || (op_q == OP_RSVD7);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_n;
   end

   // IDLE drains the pending slot first; otherwise a fresh command bypasses it.
   always_comb begin
      state_n  = state;
      take_buf = 1'b0;
      take_in  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (buf_valid) begin
               take_buf = 1'b1;
               state_n  = ST_REQ;
            end else if (is_mem_op(op_q)) begin
               take_in = 1'b1;
               state_n = ST_REQ;
            end
         end
         ST_REQ:   if (mem_gnt) state_n = mem_we ? ST_IDLE : ST_RWAIT;
         ST_RWAIT: if (mem_rvalid) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   assign gnt_fire  = (state == ST_REQ) && mem_gnt;
   assign rd_fire   = (state == ST_RWAIT) && mem_rvalid;
   assign mem_req   = (state == ST_REQ);
   assign fsm_state = state;

   io_cmd_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (is_mem_op(op_q) && !take_in),
      .push_we   (op_q == OP_WRITE),
      .push_data (in_q),
      .pop       (take_buf),
      .clr_err   (is_clr),
      .valid     (buf_valid),
      .we        (buf_we),
      .data      (buf_data),
      .err_ovf   (err_ovf)
   );

   // Request fields are frozen on REQ entry so they stay stable until grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mem_addr  <= '0;
      end else if (take_buf) begin
         mem_we    <= buf_we;
         mem_wdata <= buf_data;
         mem_addr  <= addr_q;
      end else if (take_in) begin
         mem_we    <= (op_q == OP_WRITE);
         mem_wdata <= in_q;
         mem_addr  <= addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          addr_q <= '0;
      else if (is_set)   addr_q <= in_q[ADDR_L-1:0];
      else if (gnt_fire) addr_q <= addr_q + ADDR_L'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         err_op <= 1'b0;
      else if (is_rsvd) err_op <= 1'b1;
      else if (is_clr)  err_op <= 1'b0;
   end

`ifdef IO_WR_CNT_EN
   logic [15:0] wr_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        wr_cnt <= '0;
      else if (is_clr) wr_cnt <= '0;
      else if (gnt_fire && mem_we && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
   end
`endif

   assign busy = (state != ST_IDLE) || buf_valid;

   always_comb begin
      status_word              = '0;
      status_word[STAT_OVF]    = err_ovf;
      status_word[STAT_OP]     = err_op;
      status_word[STAT_BUSY]   = busy;
      status_word[STAT_DONE]   = done_q;
      status_word[ADDR_L-1:0]  = addr_q;
`ifdef IO_WR_CNT_EN
      // The pad field is 12 bits wide, so the count is shown clamped at 0xFFF.
      status_word[STAT_PAD_HI:STAT_PAD_LO] = (wr_cnt > 16'h0FFF) ? 12'hFFF : wr_cnt[11:0];
`endif
   end

   // Returning read data takes priority over a coincident STATUS.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           out_q <= '0;
      else if (rd_fire)   out_q <= mem_rdata;
      else if (is_status) out_q <= status_word;
   end

   assign out_core   = out_q;
   assign exec_reset = rst_exec_q;
   assign exec_start = en_q && !en_prev && !rst_exec_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          done_q <= 1'b0;
      else if (exec_reset || exec_start) done_q <= 1'b0;
      else if (exec_done)                done_q <= 1'b1;
   end

   assign done_execution_io_core = done_q;

endmodule
